// File: rtl/proc_sal_pkg.sv
// -----------------------------------------------------------------------------
// proc_sal_pkg
// Shared definitions for the procesamiento_salidas display slice:
//   NUM_DIGITS  - number of multiplexed 7-segment digits
//   SEG_BLANK   - all segments off (active-low)
//   HEX_SEG     - nibble -> {g,f,e,d,c,b,a} table, active-low
//   disp_t      - record shown on the display {resultado, flags, alu_control}
//   digit_t     - digit scan position
// -----------------------------------------------------------------------------
package proc_sal_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   // flags = {negative, overflow, zero, carry}
   typedef struct packed {
      logic [7:0] resultado;
      logic [3:0] flags;
      logic [2:0] alu_control;
   } disp_t;

   typedef enum logic [1:0] {
      DIG_0 = 2'd0,
      DIG_1 = 2'd1,
      DIG_2 = 2'd2,
      DIG_3 = 2'd3
   } digit_t;

endpackage

// File: rtl/procesamiento_salidas_hex_a_7seg.sv
// -----------------------------------------------------------------------------
// hex_a_7seg
// Combinational nibble to 7-segment lookup (active-low segments).
// Ports:
//   nibble - 4-bit value to display
//   seg    - {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_a_7seg
   import proc_sal_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX_SEG[nibble];
   end

endmodule

// File: rtl/procesamiento_salidas.sv
// -----------------------------------------------------------------------------
// procesamiento_salidas
// Multiplexed 4-digit 7-segment driver for an ALU result. New values are
// captured on 'valid' and only committed to the display at a frame boundary,
// so a frame never shows a mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV - clock cycles each digit is shown (>= 32)
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   Resultado  - ALU result (8 bits)
//   Flags      - {Negative, Overflow, Zero, Carry}
//   ALUControl - operation code (3 bits)
//   valid      - one-cycle strobe: inputs are new
//   an         - digit anodes, active-low (registered)
//   seg        - {g,f,e,d,c,b,a}, active-low (registered)
//   dp         - decimal point, active-low (registered)
//   pending    - a captured value waits for the next frame boundary
//   frame_tick - one-cycle pulse on the digit tick where the scan wraps 3->0
//
// Build option:
//   PROC_SAL_BLANK_EN - when defined, anodes are forced off for the first 16
//                       prescaler counts of every digit (anti-ghosting).
// -----------------------------------------------------------------------------
module procesamiento_salidas #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] Resultado,
   input  logic [3:0] Flags,
   input  logic [2:0] ALUControl,
   input  logic       valid,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       pending,
   output logic       frame_tick
);

   import proc_sal_pkg::*;

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] presc;
   digit_t           idx;
   logic             digit_tick;
   logic             boundary;

   disp_t            in_rec;
   disp_t            disp_q;
   disp_t            pend_q;
   logic             pend_flag;

   logic [3:0]       nibble;
   logic [6:0]       hex_seg;
   logic             use_blank;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;

   assign digit_tick = (presc == CNT_W'(REFRESH_DIV - 1));
   assign boundary   = digit_tick && (idx == DIG_3);
   assign frame_tick = boundary;
   assign pending    = pend_flag;
   assign in_rec     = {Resultado, Flags, ALUControl};

   // ---------------------------------------------------------------- scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= DIG_0;
      end else if (digit_tick) begin
         presc <= '0;
         idx   <= digit_t'(idx + 2'd1);
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   // ------------------------------------------------------ capture/commit
   // A valid on the boundary cycle is newer than anything pending, so it
   // goes straight to the display and the pending slot is simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q    <= '0;
         pend_q    <= '0;
         pend_flag <= 1'b0;
      end else if (boundary) begin
         pend_flag <= 1'b0;
         if (valid) begin
            disp_q <= in_rec;
         end else if (pend_flag) begin
            disp_q <= pend_q;
         end
      end else if (valid) begin
         pend_q    <= in_rec;
         pend_flag <= 1'b1;
      end
   end

   // ------------------------------------------------------- digit select
   hex_a_7seg u_hex (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_comb begin
      nibble    = disp_q.resultado[3:0];
      dp_d      = ~disp_q.flags[0];
      use_blank = 1'b0;
      case (idx)
         DIG_0: begin
            nibble = disp_q.resultado[3:0];
            dp_d   = ~disp_q.flags[0];
         end
         DIG_1: begin
            nibble = disp_q.resultado[7:4];
            dp_d   = ~disp_q.flags[1];
         end
         DIG_2: begin
            nibble = {1'b0, disp_q.alu_control};
            dp_d   = ~disp_q.flags[2];
         end
         DIG_3: begin
            use_blank = 1'b1;
            dp_d      = ~disp_q.flags[3];
         end
      endcase

      seg_d = use_blank ? SEG_BLANK : hex_seg;
      an_d  = ~(NUM_DIGITS'(1) << idx);
`ifdef PROC_SAL_BLANK_EN
      if (presc < CNT_W'(16)) begin
         an_d = '1;
      end
`endif
   end

   // ------------------------------------------------------ output regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule
